// File: rtl/dds_pkg.sv
// Shared wave-select codes and key-front-end constants for the DDS generator.
package dds_pkg;

    localparam int unsigned KEY_NUM       = 4;
    localparam int unsigned DEBOUNCE_20MS = 1_000_000;

    typedef logic [KEY_NUM-1:0] wave_t;

    localparam wave_t WAVE_NONE     = 4'b0000;
    localparam wave_t WAVE_SINE     = 4'b0001;
    localparam wave_t WAVE_SQUARE   = 4'b0010;
    localparam wave_t WAVE_TRIANGLE = 4'b0100;
    localparam wave_t WAVE_SAW      = 4'b1000;

    // Keeps only the lowest set bit so simultaneous presses resolve to one key.
    function automatic wave_t lowest_onehot(input wave_t v);
        wave_t r;
        r = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_wave_ctrl_if.sv
// Key pins in, wave code out; sel_valid exists only when WAVE_SEL_PULSE_EN is defined.
interface key_wave_ctrl_if;
    import dds_pkg::*;

    wave_t key_in;
    wave_t wave_select;
`ifdef WAVE_SEL_PULSE_EN
    logic  sel_valid;

    modport slave  (input key_in, output wave_select, output sel_valid);
    modport master (output key_in, input wave_select, input sel_valid);
`else
    modport slave  (input key_in, output wave_select);
    modport master (output key_in, input wave_select);
`endif

endinterface

// File: rtl/key_wave_ctrl_filter.sv
// One key: 2-FF synchroniser, restartable debounce counter, stable level and press pulse.
module key_filter #(
    parameter int unsigned CNT_MAX = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_press
);

    localparam int unsigned CW = $clog2(CNT_MAX);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    logic w_key_s;
    logic w_diff;
    logic w_done;

    assign w_key_s = r_sync[1];
    assign w_diff  = (w_key_s != r_stable);
    assign w_done  = w_diff && (r_cnt == CW'(CNT_MAX - 1));

    // Any return to the stable level restarts the window; the count never wraps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_in};
            r_press <= w_done && !w_key_s;
            if (w_done) begin
                r_stable <= w_key_s;
                r_cnt    <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign key_press = r_press;

endmodule

// File: rtl/key_wave_ctrl.sv
// Debounced keys to one-hot wave_select toggle register; WAVE_SEL_PULSE_EN adds a sel_valid strobe.
module key_wave_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEBOUNCE_20MS
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    key_wave_ctrl_if.slave  bus
);

    wave_t w_press;
    wave_t w_pick;
    wave_t w_next;
    wave_t r_wave;

    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
        key_filter #(.CNT_MAX(CNT_MAX)) u_filter (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .key_in    (bus.key_in[gi]),
            .key_press (w_press[gi])
        );
    end

    // Lowest pressed key wins; pressing the active wave's key turns output off.
    always_comb begin
        w_pick = lowest_onehot(w_press);
        w_next = r_wave;
        if (w_pick != WAVE_NONE) begin
            w_next = (r_wave == w_pick) ? WAVE_NONE : w_pick;
        end
    end

`ifdef WAVE_SEL_PULSE_EN
    logic r_sel_valid;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wave      <= WAVE_NONE;
            r_sel_valid <= 1'b0;
        end else begin
            r_wave      <= w_next;
            r_sel_valid <= (w_next != r_wave);
        end
    end

    assign bus.sel_valid = r_sel_valid;
`else
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wave <= WAVE_NONE;
        end else begin
            r_wave <= w_next;
        end
    end
`endif

    assign bus.wave_select = r_wave;

endmodule
